// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder
//   Recovers hex nibbles from a multiplexed, active-low 7-segment display bus.
//   Each {dig_sel, seg_in} sample must be seen on STABLE_CYCLES consecutive
//   edges before it is committed. After a commit the pattern is locked and is
//   not committed again until the sample changes. Illegal digit selects and
//   unknown segment codes raise sticky error flags.
//
//   Optional build macro: SEG7_ALT_GLYPH_EN
//     When defined, the alternate glyphs 0x18 (nine without segment d) and
//     0x58 (seven with segment f) are also decoded as 9 and 7.
//
// Parameters
//   NUM_DIGITS     number of multiplexed digit positions (1..8)
//   STABLE_CYCLES  identical consecutive samples needed to commit (2..255)
//
// Ports
//   clk          system clock, rising edge
//   rst_n        synchronous reset, active-low
//   seg_in       segment lines, active-low, bit0=a .. bit6=g
//   dig_sel      digit enables, active-high, one-hot; all-zero = blanking
//   err_clr      clears the sticky error flags
//   digits_out   decoded nibbles, digit i at [4i+3:4i]
//   digit_valid  digit i holds a decoded value
//   upd_pulse    one-cycle strobe per successful commit
//   upd_index    digit index of the last successful commit
//   err_sel      sticky: a multi-hot dig_sel was committed
//   err_pat      sticky: an unknown segment pattern was committed
module seg7_scan_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  input  logic                    err_clr,
  output logic [4*NUM_DIGITS-1:0] digits_out,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    upd_pulse,
  output logic [2:0]              upd_index,
  output logic                    err_sel,
  output logic                    err_pat
);

  localparam int SW = NUM_DIGITS + 7;

  typedef enum logic {
    SETTLE = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [SW-1:0]   samp_p0;
  logic [SW-1:0]   cur;
  logic            same;
  logic            commit;

  logic [6:0]            samp_seg;
  logic [NUM_DIGITS-1:0] samp_sel;
  logic [3:0]            sel_cnt;
  logic [2:0]            sel_idx;
  logic                  sel_onehot;
  logic                  sel_multi;
  logic                  pat_known;
  logic [3:0]            pat_nib;

  // Returns {known, nibble}; unknown codes return known=0.
  function automatic logic [4:0] decode_seg(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'h40:   r = {1'b1, 4'h0};
      7'h79:   r = {1'b1, 4'h1};
      7'h24:   r = {1'b1, 4'h2};
      7'h30:   r = {1'b1, 4'h3};
      7'h19:   r = {1'b1, 4'h4};
      7'h12:   r = {1'b1, 4'h5};
      7'h02:   r = {1'b1, 4'h6};
      7'h78:   r = {1'b1, 4'h7};
      7'h00:   r = {1'b1, 4'h8};
      7'h10:   r = {1'b1, 4'h9};
      7'h08:   r = {1'b1, 4'hA};
      7'h03:   r = {1'b1, 4'hB};
      7'h46:   r = {1'b1, 4'hC};
      7'h21:   r = {1'b1, 4'hD};
      7'h06:   r = {1'b1, 4'hE};
      7'h0E:   r = {1'b1, 4'hF};
`ifdef SEG7_ALT_GLYPH_EN
      7'h18:   r = {1'b1, 4'h9};
      7'h58:   r = {1'b1, 4'h7};
`endif
      default: r = {1'b0, 4'h0};
    endcase
    return r;
  endfunction

  // Stability counter stops at STABLE_CYCLES instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c >= 8'(STABLE_CYCLES)) ? c : c + 8'd1;
  endfunction

  assign cur  = {dig_sel, seg_in};
  assign same = (cur == samp_p0);

  // The committed value equals the registered sample (commit only happens
  // when the new sample matches it), so decode from the register.
  assign samp_seg = samp_p0[6:0];
  assign samp_sel = samp_p0[SW-1:7];
  assign {pat_known, pat_nib} = decode_seg(samp_seg);

  always_comb begin
    sel_cnt = 4'd0;
    sel_idx = 3'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (samp_sel[i]) begin
        sel_cnt = sel_cnt + 4'd1;
        sel_idx = 3'(i);
      end
    end
  end

  assign sel_onehot = (sel_cnt == 4'd1);
  assign sel_multi  = (sel_cnt > 4'd1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      SETTLE: begin
        if (!same) begin
          cnt_d = 8'd1;
        end else begin
          cnt_d = sat_inc(cnt_q);
          if (cnt_d == 8'(STABLE_CYCLES)) begin
            commit  = 1'b1;
            state_d = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (!same) begin
          cnt_d   = 8'd1;
          state_d = SETTLE;
        end
      end
      default: begin
        state_d = SETTLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Stage p0: sample capture, FSM state and committed outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= SETTLE;
      cnt_q       <= 8'd0;
      samp_p0     <= '0;
      digits_out  <= '0;
      digit_valid <= '0;
      upd_pulse   <= 1'b0;
      upd_index   <= 3'd0;
      err_sel     <= 1'b0;
      err_pat     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      samp_p0   <= cur;
      upd_pulse <= commit && sel_onehot && pat_known;
      if (commit && sel_onehot) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (samp_sel[i]) begin
            if (pat_known) begin
              digits_out[4*i +: 4] <= pat_nib;
              digit_valid[i]       <= 1'b1;
            end else begin
              digit_valid[i]       <= 1'b0;
            end
          end
        end
        if (pat_known) begin
          upd_index <= sel_idx;
        end
      end
      // A new error on the clearing edge wins over err_clr.
      err_sel <= (err_sel && !err_clr) || (commit && sel_multi);
      err_pat <= (err_pat && !err_clr) || (commit && sel_onehot && !pat_known);
    end
  end

endmodule
